// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: shifter states and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and flags the last
// cycle of each bit period with a registered tick.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic Enable,
    input  logic Reset,
    input  logic run,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          tick_r;

    // next count: held at zero while idle, wraps at each bit boundary
    always_comb begin
        cnt_s = cnt_r;
        if (!run) begin
            cnt_s = '0;
        end else if (cnt_r == LAST) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end
    end

    // counter and look-ahead tick registers
    always_ff @(posedge Enable) begin
        if (Reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            tick_r <= run && (cnt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter: holding register feeding a shifter FSM,
// with every output driven straight from a flop.
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic       Enable,
    input  logic       Reset,
    input  logic       XMitGo,
    input  logic [7:0] TxData,
    output logic       TxEmpty,
    output logic       TxD,
    output logic       Busy
);

    tx_state_e  state_r, state_s;
    logic [7:0] hold_r, hold_s;
    logic [7:0] shift_r, shift_s;
    logic [2:0] bit_idx_r, bit_idx_s;
    logic       tx_empty_r, tx_empty_s;
    logic       txd_r, txd_s;
    logic       busy_r;
    logic       tick_s;
    logic       run_s;
    logic       accept_s;
    logic       load_s;

    assign run_s    = (state_r != IDLE);
    assign accept_s = XMitGo && tx_empty_r;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .Enable (Enable),
        .Reset  (Reset),
        .run    (run_s),
        .tick   (tick_s)
    );

    // shifter next-state, serial bit and holding-register handshake
    always_comb begin
        state_s    = state_r;
        hold_s     = hold_r;
        shift_s    = shift_r;
        bit_idx_s  = bit_idx_r;
        tx_empty_s = tx_empty_r;
        txd_s      = txd_r;
        load_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (!tx_empty_r) begin
                    load_s = 1'b1;
                end else begin
                    txd_s = STOP_BIT;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s   = DATA;
                    bit_idx_s = 3'd0;
                    txd_s     = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                end else begin
                    txd_s = START_BIT;
                end
            end
            DATA: begin
                if (tick_s && (bit_idx_r == 3'(DATA_BITS - 1))) begin
                    state_s = STOP;
                    txd_s   = STOP_BIT;
                end else if (tick_s) begin
                    bit_idx_s = bit_idx_r + 3'd1;
                    txd_s     = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                end else begin
                    txd_s = txd_r;
                end
            end
            STOP: begin
                // a full holding register chains straight into the next start bit
                if (tick_s && !tx_empty_r) begin
                    load_s = 1'b1;
                end else if (tick_s) begin
                    state_s = IDLE;
                    txd_s   = STOP_BIT;
                end else begin
                    txd_s = STOP_BIT;
                end
            end
            default: begin
                state_s = IDLE;
                txd_s   = STOP_BIT;
            end
        endcase

        // a load frees the holding register, so no request can be accepted on the same edge
        if (load_s) begin
            state_s    = START;
            shift_s    = hold_r;
            bit_idx_s  = 3'd0;
            txd_s      = START_BIT;
            tx_empty_s = 1'b1;
        end else if (accept_s) begin
            hold_s     = TxData;
            tx_empty_s = 1'b0;
        end else begin
            hold_s = hold_r;
        end
    end

    // state and output registers; reset aborts any frame and drops a held byte
    always_ff @(posedge Enable) begin
        if (Reset) begin
            state_r    <= IDLE;
            hold_r     <= 8'h00;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            tx_empty_r <= 1'b1;
            txd_r      <= STOP_BIT;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_r     <= hold_s;
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            tx_empty_r <= tx_empty_s;
            txd_r      <= txd_s;
            busy_r     <= (state_s != IDLE);
        end
    end

    assign TxEmpty = tx_empty_r;
    assign TxD     = txd_r;
    assign Busy    = busy_r;

endmodule
